miinst_queue: RTL and testbench

MIINST_QUEUE -- requirements
Module: miinst_queue

---
 rtl/miinst_queue.sv | 132 +++++++++++++
 tb/tb_miinst_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/miinst_queue.sv
// Micro-instruction queue between fetch and decode.
// Fetch offers up to WR_N slots per cycle (a contiguous valid prefix); decode
// sees up to RD_N oldest entries with first-word fall-through and consumes
// rd_take of them. Flush empties the queue; protocol misuse sets a sticky err.
module miinst_queue #(
  parameter int ENTRY_W = 64,
  parameter int DEPTH   = 16,
  parameter int WR_N    = 4,
  parameter int RD_N    = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [WR_N*ENTRY_W-1:0]      wr_data,
  input  logic [WR_N-1:0]              wr_valid,
  output logic                         wr_ready,
  output logic [RD_N*ENTRY_W-1:0]      rd_data,
  output logic [RD_N-1:0]              rd_valid,
  input  logic [$clog2(RD_N+1)-1:0]    rd_take,
  input  logic                         stall,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Circular storage; contents are never reset, only the pointers are.
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_reg, err_next;

  logic [CNT_W-1:0] push_len;
  logic             prefix_run;
  logic [CNT_W-1:0] free_slots;
  logic             active;
  logic             push_try;
  logic             push_en;
  logic             overflow;
  logic [CNT_W-1:0] take_ext;
  logic             underflow;
  logic [CNT_W-1:0] pop_n;
  logic [CNT_W-1:0] push_n;

  // Push length is the run of 1s in wr_valid starting at slot 0.
  always_comb begin
    push_len   = '0;
    prefix_run = 1'b1;
    for (int i = 0; i < WR_N; i++) begin
      if (prefix_run && wr_valid[i]) begin
        push_len = push_len + CNT_W'(1);
      end else begin
        prefix_run = 1'b0;
      end
    end
  end

  // Ready depends only on registered occupancy so fetch never waits on decode.
  assign free_slots = CNT_W'(DEPTH) - count_reg;
  assign wr_ready   = (free_slots >= CNT_W'(WR_N));

  assign active    = !stall && !flush;
  assign push_try  = active && (push_len != '0);
  assign push_en   = push_try && wr_ready;
  assign overflow  = push_try && !wr_ready;
  assign take_ext  = CNT_W'(rd_take);
  assign underflow = active && (take_ext > count_reg);
  assign push_n    = push_en ? push_len : '0;

  // Pop is clamped to the current occupancy; an over-take is flagged as err.
  always_comb begin
    pop_n = '0;
    if (active) begin
      pop_n = underflow ? count_reg : take_ext;
    end
  end

  // Next-state pointers and occupancy; flush overrides everything else.
  always_comb begin
    head_next  = head_reg + PTR_W'(pop_n);
    tail_next  = tail_reg + PTR_W'(push_n);
    count_next = count_reg + push_n - pop_n;
    err_next   = err_reg | overflow | underflow;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  // Queue control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  // Storage write of the accepted prefix; pointer arithmetic wraps naturally.
  always_ff @(posedge clk) begin
    if (rstn && push_en) begin
      for (int i = 0; i < WR_N; i++) begin
        if (CNT_W'(i) < push_len) begin
          mem[tail_reg + PTR_W'(i)] <= wr_data[i*ENTRY_W +: ENTRY_W];
        end
      end
    end
  end

  // Fall-through read of the RD_N oldest entries, oldest in slot 0.
  genvar gi;
  generate
    for (gi = 0; gi < RD_N; gi++) begin : g_rd
      assign rd_data[gi*ENTRY_W +: ENTRY_W] = mem[head_reg + PTR_W'(gi)];
      assign rd_valid[gi] = (count_reg > CNT_W'(gi));
    end
  endgenerate

  assign count = count_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_miinst_queue.sv
// Directed bench for miinst_queue with default parameters
// (ENTRY_W=64, DEPTH=16, WR_N=4, RD_N=2).
module tb_miinst_queue;

  logic         clk;
  logic         rstn;
  logic [255:0] wr_data;
  logic [3:0]   wr_valid;
  logic         wr_ready;
  logic [127:0] rd_data;
  logic [1:0]   rd_valid;
  logic [1:0]   rd_take;
  logic         stall;
  logic         flush;
  logic [4:0]   count;
  logic         err;

  int errors = 0;
  int checks = 0;

  miinst_queue dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_take  (rd_take),
    .stall    (stall),
    .flush    (flush),
    .count    (count),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_data  = '0;
    wr_valid = '0;
    rd_take  = '0;
    stall    = 1'b0;
    flush    = 1'b0;
  endtask

  // One cycle of stimulus: slot i carries base+i.
  task automatic cycle(input logic [63:0] base, input logic [3:0] mask,
                       input int take, input logic st, input logic fl);
    for (int i = 0; i < 4; i++) wr_data[i*64 +: 64] = base + 64'(i);
    wr_valid = mask;
    rd_take  = 2'(take);
    stall    = st;
    flush    = fl;
    step();
    idle_inputs();
    $display("txn base=%h mask=%b take=%0d stall=%b flush=%b -> count=%0d rd_valid=%b wr_ready=%b err=%b",
             base, mask, take, st, fl, count, rd_valid, wr_ready, err);
  endtask

  task automatic check_count(input string tag, input int exp);
    chk(tag, 128'(count), 128'(exp));
  endtask

  task automatic check_pair(input string tag, input logic [63:0] lo, input logic [63:0] hi);
    chk(tag, rd_data, {hi, lo});
  endtask

  task automatic check_flags(input string tag, input logic [1:0] v, input logic rdy, input logic e);
    chk({tag, "_rd_valid"}, 128'(rd_valid), 128'(v));
    chk({tag, "_wr_ready"}, 128'(wr_ready), 128'(rdy));
    chk({tag, "_err"},      128'(err),      128'(e));
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    check_count("reset_count", 0);
    check_flags("reset", 2'b00, 1'b1, 1'b0);
    rstn = 1'b1;
    step();

    // Basic push of A..D then two pops of two.
    cycle(64'hA0, 4'b1111, 0, 1'b0, 1'b0);
    check_count("basic_count", 4);
    check_flags("basic", 2'b11, 1'b1, 1'b0);
    check_pair("basic_rd", 64'hA0, 64'hA1);
    cycle(64'h0, 4'b0000, 2, 1'b0, 1'b0);
    check_count("pop1_count", 2);
    check_pair("pop1_rd", 64'hA2, 64'hA3);
    cycle(64'h0, 4'b0000, 2, 1'b0, 1'b0);
    check_count("pop2_count", 0);
    chk("pop2_rd_valid", 128'(rd_valid), 128'(2'b00));

    // Partial mask 1011 accepts only the first two slots.
    cycle(64'hB0, 4'b1011, 0, 1'b0, 1'b0);
    check_count("mask_count", 2);
    check_pair("mask_rd", 64'hB0, 64'hB1);
    cycle(64'h0, 4'b0000, 2, 1'b0, 1'b0);
    check_count("mask_pop_count", 0);

    // Fill from pointer 6: third push lands at 14,15,0,1. Fifth push overflows.
    for (int n = 0; n < 4; n++) begin
      cycle(64'h100 + 64'(4*n), 4'b1111, 0, 1'b0, 1'b0);
      check_count("fill_count", 4*(n+1));
      chk("fill_wr_ready", 128'(wr_ready), 128'(n < 3));
      chk("fill_err", 128'(err), 128'(0));
    end
    cycle(64'h200, 4'b1111, 0, 1'b0, 1'b0);
    check_count("ovf_count", 16);
    check_flags("ovf", 2'b11, 1'b0, 1'b1);
    for (int n = 0; n < 8; n++) begin
      check_pair("drain_rd", 64'h100 + 64'(2*n), 64'h101 + 64'(2*n));
      cycle(64'h0, 4'b0000, 2, 1'b0, 1'b0);
    end
    check_count("drain_count", 0);

    // Build count=6 at pointers 6..11, then push+pop under stall and without.
    cycle(64'hC0, 4'b1111, 0, 1'b0, 1'b0);
    cycle(64'hC4, 4'b0011, 0, 1'b0, 1'b0);
    check_count("six_count", 6);
    cycle(64'hD0, 4'b1111, 2, 1'b1, 1'b0);
    check_count("stall_count", 6);
    check_pair("stall_rd", 64'hC0, 64'hC1);
    cycle(64'hD0, 4'b1111, 2, 1'b0, 1'b0);
    check_count("pushpop_count", 8);
    check_pair("pushpop_rd", 64'hC2, 64'hC3);
    cycle(64'h0, 4'b0000, 1, 1'b0, 1'b0);
    check_count("take1_count", 7);
    check_pair("take1_rd", 64'hC3, 64'hC4);
    cycle(64'h0, 4'b0000, 2, 1'b0, 1'b0);
    check_pair("odd_rd_a", 64'hC5, 64'hD0);
    cycle(64'h0, 4'b0000, 2, 1'b0, 1'b0);
    check_pair("odd_rd_b", 64'hD1, 64'hD2);
    cycle(64'h0, 4'b0000, 2, 1'b0, 1'b0);
    check_count("one_left_count", 1);
    chk("one_left_rd_valid", 128'(rd_valid), 128'(2'b01));
    chk("one_left_rd0", 128'(rd_data[63:0]), 128'(64'hD3));
    // Head sits at 15; the read window spans 15 and 0.
    cycle(64'hE0, 4'b1111, 0, 1'b0, 1'b0);
    check_count("wrap_count", 5);
    check_pair("wrap_rd", 64'hD3, 64'hE0);
    cycle(64'h0, 4'b0000, 2, 1'b0, 1'b0);
    check_pair("wrap_rd2", 64'hE1, 64'hE2);

    // Flush beats stall and push; err stays as it was.
    cycle(64'hF0, 4'b1111, 0, 1'b0, 1'b0);
    cycle(64'hF4, 4'b0011, 0, 1'b0, 1'b0);
    check_count("nine_count", 9);
    cycle(64'h250, 4'b1111, 2, 1'b1, 1'b1);
    check_count("flush_count", 0);
    check_flags("flush", 2'b00, 1'b1, 1'b1);
    cycle(64'h300, 4'b1111, 0, 1'b0, 1'b0);
    check_count("postflush_count", 4);
    check_pair("postflush_rd", 64'h300, 64'h301);

    // Reset asserted mid-operation with a push pending.
    rstn = 1'b0;
    cycle(64'h400, 4'b1111, 0, 1'b0, 1'b0);
    check_count("midrst_count", 0);
    check_flags("midrst", 2'b00, 1'b1, 1'b0);
    rstn = 1'b1;
    step();
    check_count("midrst_after_count", 0);

    // Underflow: count=1 with rd_take=2.
    cycle(64'h500, 4'b0001, 0, 1'b0, 1'b0);
    check_count("uf_pre_count", 1);
    chk("uf_pre_rd0", 128'(rd_data[63:0]), 128'(64'h500));
    cycle(64'h0, 4'b0000, 2, 1'b0, 1'b0);
    check_count("uf_count", 0);
    chk("uf_err", 128'(err), 128'(1));
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    check_count("final_count", 0);
    check_flags("final", 2'b00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
